// File: rtl/apb_gpio_ctrl.sv
// APB slave GPIO peripheral: output register with set/clear aliases,
// synchronised and debounced inputs, and a level interrupt raised on
// selectable debounced edges. One wait state on every APB access.
module apb_gpio_ctrl #(
    parameter int                OUT_W   = 8,
    parameter int                IN_W    = 8,
    parameter int                DEB_W   = 16,
    parameter logic [DEB_W-1:0]  DEB_RST = 16'd1000,
    parameter logic [31:0]       ID_VAL  = 32'h6770_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       S_APB_PADDR,
    input  logic              S_APB_PSEL,
    input  logic              S_APB_PENABLE,
    input  logic              S_APB_PWRITE,
    input  logic [31:0]       S_APB_PWDATA,
    output logic              S_APB_PREADY,
    output logic [31:0]       S_APB_PRDATA,
    output logic              S_APB_PSLVERR,
    output logic [OUT_W-1:0]  gpio_out,
    input  logic [IN_W-1:0]   gpio_in,
    output logic              irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [DEB_W-1:0] CNT_ONE = {{(DEB_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic              r_pready;
    logic [31:0]       r_prdata;
    logic              r_pslverr;
    logic [OUT_W-1:0]  r_out;
    logic [IN_W-1:0]   r_irq_en;
    logic [IN_W-1:0]   r_irq_stat;
    logic [IN_W-1:0]   r_irq_edge;
    logic [DEB_W-1:0]  r_deb_lim;
    logic              r_irq;
    logic [IN_W-1:0]   r_sync1;
    logic [IN_W-1:0]   r_sync2;
    logic [IN_W-1:0]   r_deb;
    logic [IN_W-1:0]   r_deb_d;
    logic [DEB_W-1:0]  r_cnt [IN_W];

    logic [9:0]        w_idx;
    logic              w_err;
    logic              w_wr;
    logic [31:0]       w_rdata;
    logic [IN_W-1:0]   w_w1c;
    logic [IN_W-1:0]   w_evt;
    logic              w_unused;

    assign w_idx    = S_APB_PADDR[11:2];
    // Unmapped offsets always error; IN and ID are read-only.
    assign w_err    = (w_idx > 10'd8) ||
                      (S_APB_PWRITE && ((w_idx == 10'd3) || (w_idx == 10'd8)));
    assign w_wr     = (r_state == ST_DONE) && S_APB_PSEL && S_APB_PENABLE &&
                      S_APB_PWRITE && !w_err;
    assign w_unused = ^{S_APB_PADDR[1:0], S_APB_PWDATA};

    // Edge events: rising or falling per bit, taken from the debounced value.
    assign w_evt = (~r_irq_edge & r_deb & ~r_deb_d) | (r_irq_edge & ~r_deb & r_deb_d);

    // Read mux and W1C mask for IRQ_STAT.
    always_comb begin
        w_rdata = '0;
        w_w1c   = '0;
        case (w_idx)
            10'd0: w_rdata[OUT_W-1:0] = r_out;
            10'd3: w_rdata[IN_W-1:0]  = r_deb;
            10'd4: w_rdata[IN_W-1:0]  = r_irq_en;
            10'd5: w_rdata[IN_W-1:0]  = r_irq_stat;
            10'd6: w_rdata[IN_W-1:0]  = r_irq_edge;
            10'd7: w_rdata[DEB_W-1:0] = r_deb_lim;
            10'd8: w_rdata            = ID_VAL;
            default: w_rdata          = '0;
        endcase
        if (w_wr && (w_idx == 10'd5)) begin
            w_w1c = S_APB_PWDATA[IN_W-1:0];
        end
    end

    // APB handshake FSM: IDLE -> WAIT -> DONE -> IDLE; PSEL loss aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (S_APB_PSEL && !S_APB_PENABLE) r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (!S_APB_PSEL)        r_state <= ST_IDLE;
                    else if (S_APB_PENABLE) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Response registers: valid only during the DONE cycle, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if ((r_state == ST_WAIT) && S_APB_PSEL && S_APB_PENABLE) begin
            r_pready  <= 1'b1;
            r_prdata  <= w_err ? 32'd0 : w_rdata;
            r_pslverr <= w_err;
        end else begin
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end
    end

    // Writable registers, committed on the DONE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_irq_en   <= '0;
            r_irq_edge <= '0;
            r_deb_lim  <= DEB_RST;
        end else if (w_wr) begin
            case (w_idx)
                10'd0: r_out      <= S_APB_PWDATA[OUT_W-1:0];
                10'd1: r_out      <= r_out | S_APB_PWDATA[OUT_W-1:0];
                10'd2: r_out      <= r_out & ~S_APB_PWDATA[OUT_W-1:0];
                10'd4: r_irq_en   <= S_APB_PWDATA[IN_W-1:0];
                10'd6: r_irq_edge <= S_APB_PWDATA[IN_W-1:0];
                10'd7: r_deb_lim  <= S_APB_PWDATA[DEB_W-1:0];
                default: ;
            endcase
        end
    end

    // Interrupt status: a new event beats a simultaneous W1C; irq follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_evt;
            r_irq      <= |(r_irq_stat & r_irq_en);
        end
    end

    // Two-flop synchroniser followed by per-bit debounce counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int i = 0; i < IN_W; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < IN_W; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] >= r_deb_lim) begin
                    // ">=" so a limit lowered mid-count still fires promptly.
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign S_APB_PREADY  = r_pready;
    assign S_APB_PRDATA  = r_prdata;
    assign S_APB_PSLVERR = r_pslverr;
    assign gpio_out      = r_out;
    assign irq           = r_irq;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Directed bench for apb_gpio_ctrl with an APB response scoreboard.
module tb_apb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        is_rd;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    apb_gpio_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .S_APB_PADDR   (paddr),
        .S_APB_PSEL    (psel),
        .S_APB_PENABLE (penable),
        .S_APB_PWRITE  (pwrite),
        .S_APB_PWDATA  (pwdata),
        .S_APB_PREADY  (pready),
        .S_APB_PRDATA  (prdata),
        .S_APB_PSLVERR (pslverr),
        .gpio_out      (gpio_out),
        .gpio_in       (gpio_in),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full APB transfer; expectation queued at drive time, popped at PREADY.
    task automatic xfer(input string tag, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_err);
        exp_t e;
        int   n;
        e.tag = tag; e.is_rd = !wr; e.data = exp_data; e.err = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        while (pready !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        chk({e.tag, "_latency"}, 32'(n), 32'd1);
        if (pready === 1'b1) begin
            if (e.is_rd) chk({e.tag, "_prdata"}, prdata, e.data);
            chk({e.tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] d, input logic err);
        xfer(tag, 1'b0, a, 32'd0, d, err);
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [31:0] d, input logic err);
        xfer(tag, 1'b1, a, d, 32'd0, err);
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = '0;
        cyc(3);
        rst = 1'b0;
        chk("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        chk("rst_pready", {31'd0, pready}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        rd("rd_deblim", 12'h01C, 32'h0000_03E8, 1'b0);
        rd("rd_id", 12'h020, 32'h6770_0001, 1'b0);
        rd("rd_out0", 12'h000, 32'd0, 1'b0);

        // Output register and set/clear aliases.
        wr("wr_out", 12'h000, 32'hA5, 1'b0);
        chk("gpio_a5", {24'd0, gpio_out}, 32'hA5);
        wr("wr_set", 12'h004, 32'h0F, 1'b0);
        chk("gpio_af", {24'd0, gpio_out}, 32'hAF);
        wr("wr_clr", 12'h008, 32'h81, 1'b0);
        chk("gpio_2e", {24'd0, gpio_out}, 32'h2E);
        rd("rd_out2e", 12'h000, 32'h2E, 1'b0);
        rd("rd_set0", 12'h004, 32'd0, 1'b0);

        // Debounce, limit 4: deb changes on the 7th edge after the pin.
        wr("wr_deb4", 12'h01C, 32'd4, 1'b0);
        gpio_in[0] = 1'b1;
        cyc(4);
        rd("rd_in_early", 12'h00C, 32'h00, 1'b0);
        rd("rd_in_late", 12'h00C, 32'h01, 1'b0);
        gpio_in[1] = 1'b1;
        cyc(3);
        gpio_in[1] = 1'b0;
        cyc(10);
        rd("rd_in_glitch", 12'h00C, 32'h01, 1'b0);
        chk("irq_disabled", {31'd0, irq}, 32'd0);

        // Interrupt on rising edge of bit 0.
        gpio_in[0] = 1'b0;
        cyc(12);
        wr("wr_stat_clrall", 12'h014, 32'hFF, 1'b0);
        rd("rd_stat_zero", 12'h014, 32'd0, 1'b0);
        wr("wr_en", 12'h010, 32'h01, 1'b0);
        wr("wr_edge0", 12'h018, 32'h00, 1'b0);
        rd("rd_en", 12'h010, 32'h01, 1'b0);
        chk("irq_before_rise", {31'd0, irq}, 32'd0);
        gpio_in[0] = 1'b1;
        cyc(12);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        rd("rd_stat1", 12'h014, 32'h01, 1'b0);
        wr("wr_w1c", 12'h014, 32'h01, 1'b0);
        chk("irq_w1c_lag", {31'd0, irq}, 32'd1);
        cyc(1);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        gpio_in[2] = 1'b1;
        cyc(12);
        rd("rd_stat4", 12'h014, 32'h04, 1'b0);
        chk("irq_masked", {31'd0, irq}, 32'd0);

        // Falling edge selection on bit 0.
        wr("wr_edge1", 12'h018, 32'h01, 1'b0);
        rd("rd_edge1", 12'h018, 32'h01, 1'b0);
        gpio_in[0] = 1'b0;
        cyc(12);
        chk("irq_fall", {31'd0, irq}, 32'd1);
        rd("rd_stat5", 12'h014, 32'h05, 1'b0);
        rd("rd_in4", 12'h00C, 32'h04, 1'b0);

        // Error responses.
        wr("wr_in_err", 12'h00C, 32'hFF, 1'b1);
        rd("rd_in_after_err", 12'h00C, 32'h04, 1'b0);
        rd("rd_unmapped", 12'h024, 32'd0, 1'b1);
        wr("wr_id_err", 12'h020, 32'h0, 1'b1);
        wr("wr_unmapped", 12'h0FC, 32'hFF, 1'b1);
        chk("gpio_after_err", {24'd0, gpio_out}, 32'h2E);

        // Reset during WAIT of a write: nothing commits.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h000; pwrite = 1'b1; pwdata = 32'hFF;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rstw_gpio_out", {24'd0, gpio_out}, 32'd0);
        chk("rstw_pready", {31'd0, pready}, 32'd0);
        chk("rstw_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        cyc(2);
        chk("rstw_gpio_hold", {24'd0, gpio_out}, 32'd0);
        rd("rd_deblim_rst", 12'h01C, 32'h0000_03E8, 1'b0);
        rd("rd_edge_rst", 12'h018, 32'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_gpio_ctrl.md
Name: apb_gpio_ctrl

Overview:
Parametrised APB slave GPIO peripheral that replaces the fixed 8-bit led/sw pins of the CPU subsystem with a register-mapped block. It drives OUT_W output pins, samples IN_W input pins through a synchroniser and per-bit debouncer, and raises a level interrupt on selected debounced edges. It sits on the subsystem's APB master port, one select line per instance.

Parameters:
OUT_W, 8, number of output pins (1..32)
IN_W, 8, number of input pins (1..32)
DEB_W, 16, width of debounce counters and DEB_LIMIT register
DEB_RST, 16'd1000, reset value of DEB_LIMIT
ID_VAL, 32'h6770_0001, constant returned by ID register

Ports:
clk  in  1  system clock (same clock as APB PCLK)
rst  in  1  synchronous active-high reset
S_APB_PADDR  in  12  byte address; bits [1:0] ignored
S_APB_PSEL  in  1  slave select
S_APB_PENABLE  in  1  access phase
S_APB_PWRITE  in  1  1 = write
S_APB_PWDATA  in  32  write data
S_APB_PREADY  out  1  transfer complete
S_APB_PRDATA  out  32  read data
S_APB_PSLVERR  out  1  error response
gpio_out  out  OUT_W  output pins (e.g. led)
gpio_in  in  IN_W  asynchronous input pins (e.g. sw)
irq  out  1  level interrupt

Behaviour:
- One clock, clk; rst synchronous active-high, sampled on rising edge only.
- Reset values: gpio_out=0, PRDATA=0, PREADY=0, PSLVERR=0, irq=0, IRQ_EN=0, IRQ_STAT=0, IRQ_EDGE=0, DEB_LIMIT=DEB_RST, sync FFs=0, debounced value=0, debounce counters=0.
- APB, one wait state: setup (PSEL & !PENABLE) -> first access cycle (PSEL & PENABLE) PREADY=0 -> second access cycle PREADY=1 with PRDATA/PSLVERR valid, write committed on that edge. PREADY is a 1-cycle pulse; FSM IDLE->WAIT->DONE->IDLE. PSEL dropping mid-transfer returns to IDLE with no write. PRDATA=0 outside DONE.
- Register map (offset, access):
  0x00 OUT RW, bits [OUT_W-1:0]; gpio_out = OUT.
  0x04 OUT_SET WO: OUT |= PWDATA. Reads 0.
  0x08 OUT_CLR WO: OUT &= ~PWDATA. Reads 0.
  0x0C IN RO: debounced inputs, zero-extended.
  0x10 IRQ_EN RW [IN_W-1:0].
  0x14 IRQ_STAT RW1C [IN_W-1:0].
  0x18 IRQ_EDGE RW: per bit 0 = rising, 1 = falling.
  0x1C DEB_LIMIT RW [DEB_W-1:0].
  0x20 ID RO = ID_VAL.
- PSLVERR=1 in DONE for: unmapped offset (>0x20), write to IN or ID. Erroneous writes change no state. Unused upper bits read 0, write-ignored.
- Input path: 2-FF synchroniser per bit -> s[i]. Debouncer per bit: if s[i]==deb[i] counter cleared; else counter increments; when counter==DEB_LIMIT, deb[i]<=s[i] and counter cleared. DEB_LIMIT=0: deb follows s one cycle later. Pin to IN latency = 2 + DEB_LIMIT + 1 cycles for a stable change. Glitch shorter than DEB_LIMIT cycles never reaches deb. Counter saturates at all-ones (unreachable unless DEB_LIMIT = max).
- Writing DEB_LIMIT mid-count: new limit applies next cycle; counter >= new limit triggers update on the next cycle.
- Edge event: e[i] = deb rising (IRQ_EDGE[i]=0) or falling (=1), registered from deb change. IRQ_STAT[i] set by e[i] regardless of IRQ_EN. Set and W1C in the same cycle: set wins.
- irq = |(IRQ_STAT & IRQ_EN), registered (1 cycle after STAT/EN update).
- OUT_SET and OUT_CLR writes are independent commits; a single write affects only its own register.

Test Plan:
- Reset, then read 0x1C -> 0x3E8, 0x20 -> 0x67700001, 0x00 -> 0; every read has PREADY high on the 3rd cycle after setup, PSLVERR=0.
- Write 0x00=0xA5, OUT_SET 0x0F, OUT_CLR 0x81 -> gpio_out goes 0xA5, 0xAF, 0x2E; read 0x00 = 0x2E.
- DEB_LIMIT=4: gpio_in[0] 0->1 held 10 cycles -> IN reads 0x01 after 7 cycles; 3-cycle pulse on gpio_in[1] -> IN bit1 stays 0.
- IRQ_EN=0x01, IRQ_EDGE=0: debounced rise on bit0 -> IRQ_STAT=0x01, irq=1; write 0x14=0x01 -> irq=0 next cycle; rise on bit2 sets STAT bit2, irq stays 0.
- Write to 0x0C, read 0x24 -> PSLVERR=1 in DONE, IN unchanged, PRDATA=0.
- rst asserted during WAIT of a write to 0x00=0xFF -> gpio_out=0, PREADY=0 next cycle, no write committed.
